boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Program loader upstream of the Cpu's instruction RAM; replaces the simulation-only memory preload with a hardware byte-stream path.
- Receives a framed byte stream (from a UART receiver or bench driver) and assembles bytes into instruction words.
- Writes the words into RAM from address 0, verifies a checksum, and only then releases the CPU from hold.

Parameters:
- DATA_WIDTH, 16, instruction/RAM word width in bits; multiple of 8, at least 8.
- ADDR_WIDTH, 8, RAM address width; maximum program size is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle when in_valid is also high.
- mem_we  out  1  RAM write strobe, one-cycle pulse per word.
- mem_addr  out  ADDR_WIDTH  RAM write address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- cpu_hold  out  1  1 = hold CPU in reset; top level maps this to the CPU reset polarity.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; level signal.
- error  out  1  last load failed; level signal.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - cpu_hold=1; mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, words_loaded=0, in_ready=0.
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte, forming 16-bit word count N.
  - N words, each sent as DATA_WIDTH/8 bytes, most significant byte first.
  - One checksum byte = XOR of all preceding frame bytes (both length bytes and all data bytes).
- Byte transfer: a byte is accepted on a rising edge with in_valid=1 and in_ready=1.
- in_ready: combinational from state; 1 in LEN_HI, LEN_LO, DATA and CHECK, 0 elsewhere. There is no backpressure inside a receive state.
- States:
  - IDLE: start -> LEN_HI. Clears done, error, words_loaded and the running checksum; cpu_hold stays 1.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte, then:
    - N > 2^ADDR_WIDTH -> ERROR, with no writes.
    - N = 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: shift accepted bytes into the word register. On the final byte of a word:
    - the next cycle has mem_we=1, mem_addr = word index, mem_wdata = assembled word;
    - words_loaded increments in that same cycle.
    - Bytes for the next word may be accepted during the write cycle.
    - After the Nth word's final byte -> CHECK.
  - CHECK: accept byte.
    - Equals the running XOR -> DONE; done=1, cpu_hold=0 from the next cycle.
    - Mismatch -> ERROR; error=1, cpu_hold stays 1.
  - DONE: cpu_hold=0. start -> LEN_HI with cpu_hold=1 and done=0 in that same next cycle (reload).
  - ERROR: cpu_hold=1. start -> LEN_HI and clears error.
- busy = 1 in LEN_HI, LEN_LO, DATA and CHECK.
- The last data write completes before done rises.
- start while busy: ignored.
- in_valid in IDLE/DONE/ERROR: ignored, since in_ready=0.
- mem_addr never wraps, because N is bounded by 2^ADDR_WIDTH.
- rst mid-load: immediate return to reset values. Partially written RAM is left as is, and cpu_hold=1.
- No timeout: a stalled stream holds the current state indefinitely.

Test Plan:
1. Nominal load, DATA_WIDTH=16: start, then bytes 00 02 12 34 AB CD 42.
   - mem_we pulses at addr 0 with 0x1234 and at addr 1 with 0xABCD.
   - words_loaded=2, done=1, error=0.
   - cpu_hold falls one cycle after checksum acceptance.
2. Bad checksum: same frame ending 43.
   - Both writes occur; error=1, done=0, cpu_hold stays 1.
   - Then start plus the correct frame gives done=1.
3. Oversize length, ADDR_WIDTH=8: bytes 01 01 (N=257).
   - error=1 immediately after LEN_LO, with no mem_we pulses.
   - N=256 (01 00) is accepted.
4. Zero length: bytes 00 00 00.
   - done=1, words_loaded=0, no writes.
5. Gapped stream: in_valid toggled randomly during frame 1.
   - Identical writes and result.
   - Asserting start mid-frame has no effect.
6. Reset mid-DATA after one word written:
   - all outputs return to reset values asynchronously, state IDLE, cpu_hold=1.
   - A subsequent full load succeeds.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-stream in / RAM write out / CPU-hold status bundle for the boot loader.
interface boot_loader_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  start;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  cpu_hold;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH:0]   words_loaded;

   // Host side: issues start, drives the stream, observes RAM writes and status.
   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata,
      input  cpu_hold, busy, done, error, words_loaded
   );

   // Loader side.
   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata,
      output cpu_hold, busy, done, error, words_loaded
   );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream program loader: assembles words, writes RAM from
// address 0, verifies an XOR checksum and only then releases the CPU.
module boot_loader #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.slave  bus
);

   localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int unsigned BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int unsigned CNT_W          = ADDR_WIDTH + 1;

   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
   localparam logic [31:0]       MAX_WORDS = 32'(1) << ADDR_WIDTH;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   logic [2:0]            state_q,     state_d;
   logic [7:0]            len_hi_q,    len_hi_d;
   logic [CNT_W-1:0]      len_q,       len_d;
   logic [7:0]            csum_q,      csum_d;
   logic [DATA_WIDTH-1:0] word_q,      word_d;
   logic [BCNT_W-1:0]     bcnt_q,      bcnt_d;
   logic [CNT_W-1:0]      words_q,     words_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  cpu_hold_q,  cpu_hold_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;
   logic                  error_q,     error_d;

   logic                  rx_c;
   logic                  accept_c;
   logic [15:0]           len_full_c;
   logic [DATA_WIDTH-1:0] word_next_c;

   // Receive states advertise ready; there is no backpressure inside them.
   assign rx_c        = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
   assign accept_c    = rx_c && bus.in_valid;
   assign len_full_c  = {len_hi_q, bus.in_data};
   assign word_next_c = DATA_WIDTH'({word_q, bus.in_data});

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_hi_q    <= '0;
         len_q       <= '0;
         csum_q      <= '0;
         word_q      <= '0;
         bcnt_q      <= '0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         len_q       <= len_d;
         csum_q      <= csum_d;
         word_q      <= word_d;
         bcnt_q      <= bcnt_d;
         words_q     <= words_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      len_d       = len_q;
      csum_d      = csum_q;
      word_d      = word_q;
      bcnt_d      = bcnt_q;
      words_d     = words_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_d = S_LEN_HI;
               csum_d  = '0;
               words_d = '0;
               bcnt_d  = '0;
            end
         end
         S_LEN_HI: begin
            if (accept_c) begin
               len_hi_d = bus.in_data;
               csum_d   = csum_q ^ bus.in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept_c) begin
               csum_d = csum_q ^ bus.in_data;
               len_d  = CNT_W'(len_full_c);
               // A length beyond the RAM is rejected before any write.
               if (32'(len_full_c) > MAX_WORDS) begin
                  state_d = S_ERROR;
               end else if (len_full_c == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept_c) begin
               csum_d = csum_q ^ bus.in_data;
               word_d = word_next_c;
               if (bcnt_q == LAST_BYTE) begin
                  bcnt_d      = '0;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ADDR_WIDTH'(words_q);
                  mem_wdata_d = word_next_c;
                  words_d     = words_q + CNT_W'(1);
                  if ((words_q + CNT_W'(1)) == len_q) begin
                     state_d = S_CHECK;
                  end
               end else begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
               end
            end
         end
         S_CHECK: begin
            if (accept_c) begin
               state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERROR);
      busy_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CHECK);
   end

   assign bus.in_ready     = rx_c;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.cpu_hold     = cpu_hold_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (DATA_WIDTH=16, ADDR_WIDTH=8).
module tb_boot_loader;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   logic [7:0]  wr_addr[$];
   logic [15:0] wr_data[$];

   boot_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

   boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every RAM write, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
      end else begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.cpu_hold, bus.mem_we, bus.busy, bus.done, bus.error, bus.in_ready} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: hold,we,busy,done,err,rdy=%b required 100000",
                  {bus.cpu_hold, bus.mem_we, bus.busy, bus.done, bus.error, bus.in_ready});
      end
      n_checks++;
      if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000 || bus.words_loaded !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h wdata=%h words=%0d required 0/0/0",
                  bus.mem_addr, bus.mem_wdata, bus.words_loaded);
      end
      rst = 1'b0;
      // Stream bytes in IDLE are refused.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore: in_ready=%b busy=%b required 0/0", bus.in_ready, bus.busy);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_nominal();
      clear_writes();
      pulse_start();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL nom_busy: busy=%b hold=%b required 1/1", bus.busy, bus.cpu_hold);
      end
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 16'h1234 ||
          bus.words_loaded !== 9'd1) begin
         n_fail++;
         $display("FAIL nom_write0: we=%b addr=%h data=%h words=%0d required 1/00/1234/1",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.words_loaded);
      end
      send_byte(8'hAB);
      send_byte(8'hCD);
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd1 || bus.mem_wdata !== 16'hABCD ||
          bus.words_loaded !== 9'd2) begin
         n_fail++;
         $display("FAIL nom_write1: we=%b addr=%h data=%h words=%0d required 1/01/abcd/2",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.words_loaded);
      end
      n_checks++;
      if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL nom_pre_check: hold=%b done=%b required 1/0", bus.cpu_hold, bus.done);
      end
      send_byte(8'h42);
      n_checks++;
      if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.cpu_hold !== 1'b0 ||
          bus.busy !== 1'b0 || bus.words_loaded !== 9'd2) begin
         n_fail++;
         $display("FAIL nom_result: done=%b err=%b hold=%b busy=%b words=%0d required 1/0/0/0/2",
                  bus.done, bus.error, bus.cpu_hold, bus.busy, bus.words_loaded);
      end
      n_checks++;
      if (wr_addr.size() != 2) begin
         n_fail++;
         $display("FAIL nom_wr_count: got %0d required 2", wr_addr.size());
      end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234 ||
                   wr_addr[1] !== 8'd1 || wr_data[1] !== 16'hABCD) begin
         n_fail++;
         $display("FAIL nom_wr_log: %h:%h %h:%h required 00:1234 01:abcd",
                  wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_bad_checksum();
      clear_writes();
      pulse_start();
      // Reload from DONE re-holds the CPU immediately.
      n_checks++;
      if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reload: hold=%b done=%b busy=%b required 1/0/1",
                  bus.cpu_hold, bus.done, bus.busy);
      end
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h43);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1 || wr_addr.size() != 2) begin
         n_fail++;
         $display("FAIL bad_csum: err=%b done=%b hold=%b writes=%0d required 1/0/1/2",
                  bus.error, bus.done, bus.cpu_hold, wr_addr.size());
      end
      pulse_start();
      n_checks++;
      if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err_restart: err=%b busy=%b required 0/1", bus.error, bus.busy);
      end
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h42);
      n_checks++;
      if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_recover: done=%b err=%b hold=%b required 1/0/0",
                  bus.done, bus.error, bus.cpu_hold);
      end
   endtask

   task automatic test_length_bounds();
      logic [7:0] idx;
      clear_writes();
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      n_checks++;
      if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL oversize: err=%b busy=%b rdy=%b hold=%b required 1/0/0/1",
                  bus.error, bus.busy, bus.in_ready, bus.cpu_hold);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (wr_addr.size() != 0) begin
         n_fail++;
         $display("FAIL oversize_writes: got %0d required 0", wr_addr.size());
      end
      // 256 words {i, ~i}: each word XORs to FF, 256 of them cancel, checksum = 01^00.
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         idx = 8'(i);
         send_byte(idx);
         send_byte(~idx);
      end
      send_byte(8'h01);
      n_checks++;
      if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.words_loaded !== 9'd256) begin
         n_fail++;
         $display("FAIL max_len: done=%b err=%b words=%0d required 1/0/256",
                  bus.done, bus.error, bus.words_loaded);
      end
      n_checks++;
      if (wr_addr.size() != 256) begin
         n_fail++;
         $display("FAIL max_wr_count: got %0d required 256", wr_addr.size());
      end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 16'h00FF ||
                   wr_addr[255] !== 8'hFF || wr_data[255] !== 16'hFF00 ||
                   wr_addr[100] !== 8'h64 || wr_data[100] !== 16'h649B) begin
         n_fail++;
         $display("FAIL max_wr_log: %h:%h %h:%h %h:%h required 00:00ff 64:649b ff:ff00",
                  wr_addr[0], wr_data[0], wr_addr[100], wr_data[100], wr_addr[255], wr_data[255]);
      end
   endtask

   task automatic test_zero_length();
      clear_writes();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b1 || bus.words_loaded !== 9'd0 || wr_addr.size() != 0 || bus.cpu_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: done=%b words=%0d writes=%0d hold=%b required 1/0/0/0",
                  bus.done, bus.words_loaded, wr_addr.size(), bus.cpu_hold);
      end
   endtask

   task automatic test_gapped();
      logic [7:0] frame [7];
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      clear_writes();
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         bus.in_data = 8'hEE;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         if (i == 3) begin
            pulse_start();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.words_loaded !== 9'd0) begin
               n_fail++;
               $display("FAIL start_while_busy: busy=%b words=%0d required 1/0",
                        bus.busy, bus.words_loaded);
            end
         end
         send_byte(frame[i]);
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.words_loaded !== 9'd2 || wr_addr.size() != 2) begin
         n_fail++;
         $display("FAIL gap_result: done=%b err=%b words=%0d writes=%0d required 1/0/2/2",
                  bus.done, bus.error, bus.words_loaded, wr_addr.size());
      end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234 ||
                   wr_addr[1] !== 8'd1 || wr_data[1] !== 16'hABCD) begin
         n_fail++;
         $display("FAIL gap_wr_log: %h:%h %h:%h required 00:1234 01:abcd",
                  wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_reset_mid_load();
      pulse_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.cpu_hold, bus.mem_we, bus.busy, bus.done, bus.error, bus.in_ready} !== 6'b100000 ||
          bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000 || bus.words_loaded !== 9'd0) begin
         n_fail++;
         $display("FAIL mid_reset: flags=%b addr=%h wdata=%h words=%0d required 100000/00/0000/0",
                  {bus.cpu_hold, bus.mem_we, bus.busy, bus.done, bus.error, bus.in_ready},
                  bus.mem_addr, bus.mem_wdata, bus.words_loaded);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_writes();
      pulse_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h42);
      n_checks++;
      if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || wr_addr.size() != 2) begin
         n_fail++;
         $display("FAIL post_reset_load: done=%b hold=%b writes=%0d required 1/0/2",
                  bus.done, bus.cpu_hold, wr_addr.size());
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_length_bounds();
      test_zero_length();
      test_gapped();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
